// File: rtl/fifo_sync_pkt.sv
// First-word-fall-through AXI-stream FIFO carrying data plus TLAST, with any depth,
// optional store-and-forward packet mode, fill-level/packet counters and flush.
module fifo_sync_pkt #(
  parameter int DATA_WIDTH    = 12,
  parameter int FIFO_DEPTH    = 400,
  parameter int PACKET_MODE   = 0,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                flush,
  input  logic [DATA_WIDTH-1:0]               in_TDATA,
  input  logic                                in_TLAST,
  input  logic                                in_TVALID,
  output logic                                in_TREADY,
  output logic [DATA_WIDTH-1:0]               out_TDATA,
  output logic                                out_TLAST,
  output logic                                out_TVALID,
  input  logic                                out_TREADY,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     level,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     pkt_count,
  output logic                                almost_full,
  output logic                                almost_empty,
  output logic                                oversize
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  logic [DATA_WIDTH:0] mem [FIFO_DEPTH];

  logic [PW-1:0] w_ptr_reg, w_ptr_next;
  logic [PW-1:0] r_ptr_reg, r_ptr_next;
  logic [LW-1:0] level_reg, level_next;
  logic [LW-1:0] pkt_count_reg, pkt_count_next;
  logic          release_reg, release_next;
  logic          oversize_reg, oversize_next;

  logic [DATA_WIDTH:0] head;
  logic full, has_data, has_pkt, oversize_set, release_now;
  logic wr, rd, wr_last, rd_last;

  assign head     = mem[r_ptr_reg];
  assign full     = (level_reg == DEPTH_L);
  assign has_data = (level_reg != '0);
  assign has_pkt  = (pkt_count_reg != '0);

  // A full FIFO with no complete packet would deadlock in packet mode, so it is
  // released immediately (combinationally) and the rest streams cut-through.
  assign oversize_set = (PACKET_MODE != 0) && full && !has_pkt;
  assign release_now  = release_reg | oversize_set;

  assign out_TVALID = has_data & ((PACKET_MODE == 0) | has_pkt | release_now);
  assign in_TREADY  = !reset & !flush & !full;

  assign wr      = in_TVALID & in_TREADY;
  assign rd      = out_TVALID & out_TREADY;
  assign wr_last = wr & in_TLAST;
  assign rd_last = rd & head[DATA_WIDTH];

  assign out_TDATA    = out_TVALID ? head[DATA_WIDTH-1:0] : '0;
  assign out_TLAST    = out_TVALID & head[DATA_WIDTH];
  assign level        = level_reg;
  assign pkt_count    = pkt_count_reg;
  assign almost_full  = int'(level_reg) >= AFULL_THRESH;
  assign almost_empty = int'(level_reg) <= AEMPTY_THRESH;
  assign oversize     = oversize_reg | oversize_set;

  always_comb begin
    w_ptr_next     = w_ptr_reg;
    r_ptr_next     = r_ptr_reg;
    level_next     = level_reg;
    pkt_count_next = pkt_count_reg;
    release_next   = release_now & !rd_last;
    oversize_next  = oversize_reg | oversize_set;

    if (wr) w_ptr_next = (w_ptr_reg == LAST_PTR) ? '0 : w_ptr_reg + 1'b1;
    if (rd) r_ptr_next = (r_ptr_reg == LAST_PTR) ? '0 : r_ptr_reg + 1'b1;

    case ({wr, rd})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase

    case ({wr_last, rd_last})
      2'b10:   pkt_count_next = pkt_count_reg + 1'b1;
      2'b01:   pkt_count_next = pkt_count_reg - 1'b1;
      default: pkt_count_next = pkt_count_reg;
    endcase

    if (flush) begin
      w_ptr_next     = '0;
      r_ptr_next     = '0;
      level_next     = '0;
      pkt_count_next = '0;
      release_next   = 1'b0;
      oversize_next  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr_reg     <= '0;
      r_ptr_reg     <= '0;
      level_reg     <= '0;
      pkt_count_reg <= '0;
      release_reg   <= 1'b0;
      oversize_reg  <= 1'b0;
    end else begin
      w_ptr_reg     <= w_ptr_next;
      r_ptr_reg     <= r_ptr_next;
      level_reg     <= level_next;
      pkt_count_reg <= pkt_count_next;
      release_reg   <= release_next;
      oversize_reg  <= oversize_next;
    end
  end

  // Storage has no reset; outputs are gated by out_TVALID so stale entries never show.
  always_ff @(posedge clk) begin
    if (wr) mem[w_ptr_reg] <= {in_TLAST, in_TDATA};
  end

endmodule

// File: tb/tb_fifo_sync_pkt.sv
// Directed and scoreboard checks of fifo_sync_pkt in three configurations:
// depth 400 cut-through, depth 5 cut-through, depth 8 packet mode.
module tb_fifo_sync_pkt;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // depth 400, cut-through
  logic d4_fl = 0, d4_il = 0, d4_iv = 0, d4_or = 0;
  logic [11:0] d4_id = 0;
  logic d4_ir, d4_ol, d4_ov, d4_af, d4_ae, d4_os;
  logic [11:0] d4_od;
  logic [8:0] d4_lvl, d4_pc;

  // depth 5, cut-through, almost_full at 4, almost_empty at 1
  logic d5_fl = 0, d5_il = 0, d5_iv = 0, d5_or = 0;
  logic [11:0] d5_id = 0;
  logic d5_ir, d5_ol, d5_ov, d5_af, d5_ae, d5_os;
  logic [11:0] d5_od;
  logic [2:0] d5_lvl, d5_pc;

  // depth 8, packet mode
  logic d8_fl = 0, d8_il = 0, d8_iv = 0, d8_or = 0;
  logic [11:0] d8_id = 0;
  logic d8_ir, d8_ol, d8_ov, d8_af, d8_ae, d8_os;
  logic [11:0] d8_od;
  logic [3:0] d8_lvl, d8_pc;

  fifo_sync_pkt #(.DATA_WIDTH(12), .FIFO_DEPTH(400), .PACKET_MODE(0)) u_d4 (
    .clk(clk), .reset(reset), .flush(d4_fl),
    .in_TDATA(d4_id), .in_TLAST(d4_il), .in_TVALID(d4_iv), .in_TREADY(d4_ir),
    .out_TDATA(d4_od), .out_TLAST(d4_ol), .out_TVALID(d4_ov), .out_TREADY(d4_or),
    .level(d4_lvl), .pkt_count(d4_pc), .almost_full(d4_af), .almost_empty(d4_ae),
    .oversize(d4_os));

  fifo_sync_pkt #(.DATA_WIDTH(12), .FIFO_DEPTH(5), .PACKET_MODE(0),
                  .AFULL_THRESH(4), .AEMPTY_THRESH(1)) u_d5 (
    .clk(clk), .reset(reset), .flush(d5_fl),
    .in_TDATA(d5_id), .in_TLAST(d5_il), .in_TVALID(d5_iv), .in_TREADY(d5_ir),
    .out_TDATA(d5_od), .out_TLAST(d5_ol), .out_TVALID(d5_ov), .out_TREADY(d5_or),
    .level(d5_lvl), .pkt_count(d5_pc), .almost_full(d5_af), .almost_empty(d5_ae),
    .oversize(d5_os));

  fifo_sync_pkt #(.DATA_WIDTH(12), .FIFO_DEPTH(8), .PACKET_MODE(1)) u_d8 (
    .clk(clk), .reset(reset), .flush(d8_fl),
    .in_TDATA(d8_id), .in_TLAST(d8_il), .in_TVALID(d8_iv), .in_TREADY(d8_ir),
    .out_TDATA(d8_od), .out_TLAST(d8_ol), .out_TVALID(d8_ov), .out_TREADY(d8_or),
    .level(d8_lvl), .pkt_count(d8_pc), .almost_full(d8_af), .almost_empty(d8_ae),
    .oversize(d8_os));

  typedef struct {
    logic        fl, iv, il, ordy;
    logic [11:0] id;
    logic        e_ov;
    logic [11:0] e_od;
    logic        e_ol;
    int          e_lvl;
    logic        e_ir, e_af, e_ae;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int q[$];
    int nxt, got, sent, sz, ent;

    // fl iv il ordy id | ov od ol lvl ir af ae  (expected state before the edge)
    tbl[0]  = '{0, 1, 0, 0, 1,  0, 0,  0, 0, 1, 0, 1};
    tbl[1]  = '{0, 1, 0, 0, 2,  1, 1,  0, 1, 1, 0, 1};
    tbl[2]  = '{0, 1, 1, 1, 3,  1, 1,  0, 2, 1, 0, 0};
    tbl[3]  = '{0, 0, 0, 1, 0,  1, 2,  0, 2, 1, 0, 0};
    tbl[4]  = '{0, 1, 0, 1, 4,  1, 3,  1, 1, 1, 0, 1};
    tbl[5]  = '{0, 1, 0, 0, 5,  1, 4,  0, 1, 1, 0, 1};
    tbl[6]  = '{0, 1, 0, 0, 6,  1, 4,  0, 2, 1, 0, 0};
    tbl[7]  = '{0, 1, 0, 0, 7,  1, 4,  0, 3, 1, 0, 0};
    tbl[8]  = '{0, 1, 0, 0, 8,  1, 4,  0, 4, 1, 1, 0};
    tbl[9]  = '{0, 1, 0, 1, 9,  1, 4,  0, 5, 0, 1, 0};
    tbl[10] = '{1, 1, 0, 0, 9,  1, 5,  0, 4, 0, 1, 0};
    tbl[11] = '{0, 1, 0, 0, 10, 0, 0,  0, 0, 1, 0, 1};
    tbl[12] = '{0, 0, 0, 1, 0,  1, 10, 0, 1, 1, 0, 1};
    tbl[13] = '{0, 0, 0, 0, 0,  0, 0,  0, 0, 1, 0, 1};

    // Reset state while reset is held
    #1;
    chk("rst_ir", d4_ir, 0);
    chk("rst_ov", d4_ov, 0);
    chk("rst_lvl", d4_lvl, 0);
    chk("rst_ae", d4_ae, 1);
    chk("rst_af", d4_af, 0);
    chk("rst_od", d4_od, 0);
    chk("rst_os8", d8_os, 0);
    chk("rst_pc8", d8_pc, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_ir", d4_ir, 1);

    // Table-driven vectors on depth 5: FWFT latency, simultaneous wr/rd, wrap, full, flush
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      d5_fl = tbl[i].fl; d5_iv = tbl[i].iv; d5_il = tbl[i].il;
      d5_or = tbl[i].ordy; d5_id = tbl[i].id;
      #1;
      $display("vec %0d: ov=%0d od=%0d ol=%0d lvl=%0d ir=%0d", i, d5_ov, d5_od, d5_ol, d5_lvl, d5_ir);
      chk($sformatf("vec%0d_ov", i), d5_ov, tbl[i].e_ov);
      chk($sformatf("vec%0d_lvl", i), d5_lvl, tbl[i].e_lvl);
      chk($sformatf("vec%0d_ir", i), d5_ir, tbl[i].e_ir);
      chk($sformatf("vec%0d_af", i), d5_af, tbl[i].e_af);
      chk($sformatf("vec%0d_ae", i), d5_ae, tbl[i].e_ae);
      if (tbl[i].e_ov) begin
        chk($sformatf("vec%0d_od", i), d5_od, tbl[i].e_od);
        chk($sformatf("vec%0d_ol", i), d5_ol, tbl[i].e_ol);
      end
    end

    // Random backpressure on depth 5 against a queue model
    nxt = 0; got = 0;
    for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
      @(negedge clk);
      d5_fl = 0;
      d5_iv = (nxt < 1000) && ($urandom_range(0, 3) != 0);
      d5_id = 12'(nxt);
      d5_il = (nxt % 7 == 6);
      d5_or = ($urandom_range(0, 2) != 0);
      #1;
      sz = q.size();
      chk("rnd_level", d5_lvl, sz);
      chk("rnd_ov", d5_ov, sz > 0);
      chk("rnd_ir", d5_ir, sz < 5);
      if (d5_ov && d5_or && sz > 0) begin
        ent = q.pop_front();
        chk("rnd_data", d5_od, ent & 12'hFFF);
        chk("rnd_last", d5_ol, ent >> 12);
        got++;
      end
      if (d5_iv && d5_ir) begin
        q.push_back((int'(d5_il) << 12) | nxt);
        nxt++;
      end
    end
    chk("rnd_done", got, 1000);
    @(negedge clk);
    d5_iv = 0; d5_or = 0;
    $display("random: %0d beats transferred", got);

    // Fill / drain on depth 400
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      d4_iv = 1; d4_id = 12'(i);
      #1;
      if (i == 395) chk("fill_af395", d4_af, 0);
      if (i == 396) chk("fill_af396", d4_af, 1);
      if (i == 399) chk("fill_ir399", d4_ir, 1);
    end
    @(negedge clk);
    d4_iv = 0;
    #1;
    chk("full_lvl", d4_lvl, 400);
    chk("full_ir", d4_ir, 0);
    chk("full_af", d4_af, 1);
    chk("full_head", d4_od, 0);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      d4_or = 1;
      #1;
      chk("drain_data", d4_od, i);
      if (i >= 394) begin
        chk("drain_lvl", d4_lvl, 400 - i);
        chk("drain_ae", d4_ae, (400 - i) <= 4);
      end
    end
    @(negedge clk);
    d4_or = 0;
    #1;
    chk("drained_lvl", d4_lvl, 0);
    chk("drained_ov", d4_ov, 0);
    chk("drained_ae", d4_ae, 1);
    $display("fill/drain: 400 beats");

    // Flush at level 6 with a write attempted in the same cycle
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      d4_iv = 1; d4_id = 12'(100 + i);
    end
    @(negedge clk);
    d4_fl = 1; d4_iv = 1; d4_id = 12'd77;
    #1;
    chk("flush_lvl_before", d4_lvl, 6);
    chk("flush_ir", d4_ir, 0);
    @(negedge clk);
    d4_fl = 0; d4_iv = 0;
    #1;
    chk("flush_lvl_after", d4_lvl, 0);
    chk("flush_ov_after", d4_ov, 0);
    @(negedge clk);
    d4_iv = 1; d4_id = 12'd55;
    @(negedge clk);
    d4_iv = 0;
    #1;
    chk("post_flush_lvl", d4_lvl, 1);
    chk("post_flush_od", d4_od, 55);
    $display("flush: done");

    // Packet mode: 3-beat packet held until TLAST is stored
    @(negedge clk);
    d8_iv = 1; d8_id = 12'hA; d8_il = 0;
    #1; chk("pkt_ov0", d8_ov, 0);
    @(negedge clk);
    d8_id = 12'hB;
    #1; chk("pkt_ov1", d8_ov, 0); chk("pkt_lvl1", d8_lvl, 1);
    @(negedge clk);
    d8_id = 12'hC; d8_il = 1;
    #1; chk("pkt_ov2", d8_ov, 0); chk("pkt_pc2", d8_pc, 0);
    @(negedge clk);
    d8_iv = 0; d8_il = 0;
    #1; chk("pkt_ov3", d8_ov, 1); chk("pkt_pc3", d8_pc, 1); chk("pkt_lvl3", d8_lvl, 3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      d8_or = 1;
      #1;
      chk("pkt_rd_data", d8_od, 10 + k);
      chk("pkt_rd_last", d8_ol, k == 2);
      chk("pkt_rd_pc", d8_pc, 1);
    end
    @(negedge clk);
    d8_or = 0;
    #1;
    chk("pkt_end_pc", d8_pc, 0);
    chk("pkt_end_ov", d8_ov, 0);
    $display("packet: 3 beats");

    // Oversize: 12-beat packet through a depth-8 packet-mode FIFO
    sent = 0; got = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      d8_iv = 1; d8_id = 12'(256 + sent); d8_il = 0;
      #1;
      chk("ovs_fill_ov", d8_ov, 0);
      sent++;
    end
    @(negedge clk);
    d8_iv = 0;
    #1;
    chk("ovs_lvl", d8_lvl, 8);
    chk("ovs_ov", d8_ov, 1);
    chk("ovs_flag", d8_os, 1);
    chk("ovs_ir", d8_ir, 0);
    chk("ovs_pc", d8_pc, 0);
    for (int cyc = 0; cyc < 200 && got < 12; cyc++) begin
      @(negedge clk);
      d8_iv = (sent < 12); d8_id = 12'(256 + sent); d8_il = (sent == 11); d8_or = 1;
      #1;
      if (d8_ov) begin
        chk("ovs_data", d8_od, 256 + got);
        chk("ovs_last", d8_ol, got == 11);
        got++;
      end
      if (d8_iv && d8_ir) sent++;
    end
    chk("ovs_done", got, 12);
    @(negedge clk);
    d8_iv = 0; d8_il = 0; d8_or = 0;
    #1;
    chk("ovs_end_ov", d8_ov, 0);
    chk("ovs_end_lvl", d8_lvl, 0);
    chk("ovs_sticky", d8_os, 1);
    @(negedge clk);
    d8_fl = 1;
    @(negedge clk);
    d8_fl = 0;
    #1;
    chk("ovs_cleared", d8_os, 0);
    $display("oversize: %0d beats", got);

    // Asynchronous reset mid-burst, between clock edges
    @(negedge clk);
    d4_iv = 1; d4_id = 12'd200;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_lvl", d4_lvl, 0);
    chk("arst_ov", d4_ov, 0);
    chk("arst_ir", d4_ir, 0);
    chk("arst_ae", d4_ae, 1);
    chk("arst_od", d4_od, 0);
    @(negedge clk);
    d4_iv = 0;
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("arst_rel_lvl", d4_lvl, 0);
    chk("arst_rel_ir", d4_ir, 1);
    $display("async reset: done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
